// File: rtl/textmode_scanner.sv
// Text-mode raster engine: scan counters feed a two-stage, strobe-gated pipeline.
// Stage 1 issues the text-buffer/glyph lookup; stage 2 registers pixel and syncs.
module textmode_scanner #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int COLS     = 80,
  parameter int ADDR_W   = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pix_en,
  output logic [ADDR_W-1:0] text_addr,
  input  logic [6:0]        text_data,
  output logic [6:0]        glyph_ascii,
  output logic [3:0]        glyph_row,
  output logic [2:0]        glyph_col,
  input  logic              glyph_px,
  output logic              pixel,
  output logic              de,
  output logic              hsync,
  output logic              vsync,
  output logic              frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int HS_BEG  = H_ACTIVE + H_FP;
  localparam int HS_END  = HS_BEG + H_SYNC;
  localparam int VS_BEG  = V_ACTIVE + V_FP;
  localparam int VS_END  = VS_BEG + V_SYNC;

  // One raster position plus its decoded active/sync flags.
  typedef struct packed {
    logic [HW-1:0] h;
    logic [VW-1:0] v;
    logic          act;
    logic          hs_n;
    logic          vs_n;
  } scan_pos_t;

  localparam scan_pos_t POS_RESET = '{h: HW'(0), v: VW'(0), act: 1'b0, hs_n: 1'b1, vs_n: 1'b1};

  logic [HW-1:0]     h_cnt;
  logic [VW-1:0]     v_cnt;
  logic              h_last;
  logic              v_last;
  scan_pos_t         cur;
  scan_pos_t         p1;
  logic [ADDR_W-1:0] addr_nxt;

  // Position decode and text-cell address for the current counter value.
  always_comb begin
    // NOTE: every always_comb output is given a default first, so no path can infer a latch.
    cur      = POS_RESET;
    addr_nxt = '0;
    h_last   = (h_cnt == HW'(H_TOTAL - 1));
    v_last   = (v_cnt == VW'(V_TOTAL - 1));
    cur.h    = h_cnt;
    cur.v    = v_cnt;
    cur.act  = (h_cnt < HW'(H_ACTIVE)) && (v_cnt < VW'(V_ACTIVE));
    cur.hs_n = !((h_cnt >= HW'(HS_BEG)) && (h_cnt < HW'(HS_END)));
    cur.vs_n = !((v_cnt >= VW'(VS_BEG)) && (v_cnt < VW'(VS_END)));
    if (cur.act) begin
      addr_nxt = ADDR_W'(v_cnt >> 4) * ADDR_W'(COLS) + ADDR_W'(h_cnt >> 3);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_en) begin
      if (h_last) begin
        h_cnt <= '0;
        v_cnt <= v_last ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  // Stage 1: latch position and issue the text buffer read.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p1        <= POS_RESET;
      text_addr <= '0;
    end else if (pix_en) begin
      p1        <= cur;
      text_addr <= addr_nxt;
    end
  end

  // The ROM lookup rides between strobes on stage-1 state and the buffer read data.
  assign glyph_ascii = text_data;
  assign glyph_row   = p1.v[3:0];
  assign glyph_col   = p1.h[2:0];

  // Stage 2: register pixel and syncs together so they leave aligned.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pixel <= 1'b0;
      de    <= 1'b0;
      hsync <= 1'b1;
      vsync <= 1'b1;
    end else if (pix_en) begin
      pixel <= glyph_px & p1.act;
      de    <= p1.act;
      hsync <= p1.hs_n;
      vsync <= p1.vs_n;
    end
  end

  // p1.act separates a real (0,0) from the cleared reset state of stage 1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_start <= 1'b0;
    end else begin
      frame_start <= pix_en && p1.act && (p1.h == '0) && (p1.v == '0);
    end
  end

endmodule

// File: tb/tb_textmode_scanner.sv
// Bench for textmode_scanner on a reduced raster, checked strobe by strobe against
// a position-index model of the scan plus explicit line/frame timing measurements.
module tb_textmode_scanner;

  localparam int HA = 32, HF = 4, HS = 6, HB = 6;
  localparam int VA = 48, VF = 3, VS = 2, VB = 4;
  localparam int COLS = 4, AW = 12;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pix_en = 1'b0;
  logic [AW-1:0] text_addr;
  logic [6:0]    text_data;
  logic [6:0]    glyph_ascii;
  logic [3:0]    glyph_row;
  logic [2:0]    glyph_col;
  logic          glyph_px;
  logic          pixel, de, hsync, vsync, frame_start;

  logic [6:0] mem [0:(1<<AW)-1];
  bit         rom_mode = 1'b0;

  int n_checks = 0;
  int n_fail = 0;
  int j = 0;
  int static_err = 0;
  int fs_long = 0;

  logic          o_de, o_hs, o_vs, o_px, o_fs;
  logic [AW-1:0] o_addr;
  logic [3:0]    o_row;
  logic [2:0]    o_col;
  logic [6:0]    o_ascii;

  textmode_scanner #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .COLS(COLS), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
    .text_addr(text_addr), .text_data(text_data),
    .glyph_ascii(glyph_ascii), .glyph_row(glyph_row), .glyph_col(glyph_col),
    .glyph_px(glyph_px),
    .pixel(pixel), .de(de), .hsync(hsync), .vsync(vsync), .frame_start(frame_start)
  );

  always #10 clk = ~clk;

  always @(posedge clk) text_data <= mem[text_addr];

  function automatic logic rom_px(bit mode, logic [6:0] a, logic [3:0] r, logic [2:0] c);
    logic [7:0] a8;
    a8 = {1'b0, a};
    return mode ? (a8[c] ^ r[0]) : c[0];
  endfunction

  assign glyph_px = rom_px(rom_mode, glyph_ascii, glyph_row, glyph_col);

  // Model: raster position index idx maps to x = idx mod HT, y = (idx / HT) mod VT.
  function automatic int px_x(int idx);
    return idx % HT;
  endfunction

  function automatic int px_y(int idx);
    return (idx / HT) % VT;
  endfunction

  function automatic bit in_act(int idx);
    return (px_x(idx) < HA) && (px_y(idx) < VA);
  endfunction

  function automatic logic [AW-1:0] exp_addr(int idx);
    return in_act(idx) ? AW'((px_y(idx) / 16) * COLS + px_x(idx) / 8) : '0;
  endfunction

  // Outputs after strobe jj count from reset release; position idx reaches them two strobes late.
  function automatic logic [4:0] exp_out(int jj);
    int idx, x, y;
    logic d;
    if (jj < 2) return 5'b01100;
    idx = jj - 2;
    x = px_x(idx);
    y = px_y(idx);
    d = in_act(idx);
    return {d,
            !(x >= HA + HF && x < HA + HF + HS),
            !(y >= VA + VF && y < VA + VF + VS),
            d && rom_px(rom_mode, mem[exp_addr(idx)], 4'(y % 16), 3'(x % 8)),
            (idx % FRAME) == 0};
  endfunction

  task automatic strobe();
    int gap;
    logic [22:0] hold;
    @(negedge clk);
    pix_en = 1'b1;
    @(posedge clk);
    #1;
    j++;
    o_de = de; o_hs = hsync; o_vs = vsync; o_px = pixel; o_fs = frame_start;
    o_addr = text_addr; o_row = glyph_row; o_col = glyph_col;
    hold = {pixel, de, hsync, vsync, text_addr, glyph_row, glyph_col};
    @(negedge clk);
    pix_en = 1'b0;
    gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 4)) : 1;
    repeat (gap) begin
      @(posedge clk);
      #1;
      if ({pixel, de, hsync, vsync, text_addr, glyph_row, glyph_col} !== hold) static_err++;
      if (frame_start !== 1'b0) fs_long++;
    end
    o_ascii = glyph_ascii;
  endtask

  task automatic wait_fs(output bit found);
    found = 1'b0;
    for (int i = 0; i < FRAME + 4; i++) begin
      strobe();
      if (o_fs === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      pix_en = ~pix_en;
      @(posedge clk);
      #1;
      n_checks++;
      if ({pixel, de, hsync, vsync, frame_start} !== 5'b00110 || text_addr !== '0) begin
        n_fail++;
        $display("FAIL reset clk%0d: px/de/hs/vs/fs=%b addr=%0d, expected 00110 addr=0",
                 i, {pixel, de, hsync, vsync, frame_start}, text_addr);
      end
    end
    @(negedge clk);
    pix_en = 1'b0;
    rst_n = 1'b1;
    j = 0;
  endtask

  task automatic test_scan(input string name, input int n, input bit mode, input bit rand_text);
    logic [30:0] got, want;
    int s0, f0;
    for (int a = 0; a < (1 << AW); a++) mem[a] = rand_text ? 7'($urandom) : 7'h41;
    rom_mode = mode;
    @(posedge clk);
    #1;
    s0 = static_err;
    f0 = fs_long;
    for (int i = 0; i < n; i++) begin
      strobe();
      got  = {o_de, o_hs, o_vs, o_px, o_fs, o_addr, o_row, o_col, o_ascii};
      want = {exp_out(j), exp_addr(j - 1), 4'(px_y(j - 1) % 16), 3'(px_x(j - 1) % 8),
              mem[exp_addr(j - 1)]};
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL %s strobe %0d: {de,hs,vs,px,fs,addr,row,col,ascii} got %h expected %h",
                 name, j, got, want);
      end
    end
    n_checks++;
    if (static_err != s0 || fs_long != f0) begin
      n_fail++;
      $display("FAIL %s between-strobe: output changes %0d, frame_start extra clks %0d, expected 0 and 0",
               name, static_err - s0, fs_long - f0);
    end
  endtask

  task automatic test_addressing();
    int tx [4] = '{HA, 8, HA - 8, 0};
    int ty [4] = '{0, 16, VA - 1, VA};
    int wa [4] = '{0, 5, 11, 0};  // (y/16)*COLS + x/8 inside the active area, else 0
    bit hit;
    for (int t = 0; t < 4; t++) begin
      hit = 1'b0;
      for (int i = 0; i < FRAME + 1; i++) begin
        strobe();
        if (px_x(j - 1) == tx[t] && px_y(j - 1) == ty[t]) begin
          hit = 1'b1;
          break;
        end
      end
      n_checks++;
      if (!hit) begin
        n_fail++;
        $display("FAIL addr (%0d,%0d): position not reached within one frame", tx[t], ty[t]);
      end else if (o_addr !== AW'(wa[t])) begin
        n_fail++;
        $display("FAIL addr (%0d,%0d): text_addr=%0d expected %0d", tx[t], ty[t], o_addr, wa[t]);
      end
    end
  endtask

  // Starts on a strobe that just showed frame_start; measures the next three lines.
  task automatic measure_lines(input string name);
    bit de_a [3*HT];
    bit hs_a [3*HT];
    int de_run, hs_fall, hs_len, de_rise2, hs_fall2, s0;
    s0 = static_err;
    de_a[0] = o_de;
    hs_a[0] = o_hs;
    for (int k = 1; k < 3 * HT; k++) begin
      strobe();
      de_a[k] = o_de;
      hs_a[k] = o_hs;
    end
    de_run = 0;
    while (de_run < 3 * HT && de_a[de_run]) de_run++;
    hs_fall = -1; hs_len = 0; de_rise2 = -1; hs_fall2 = -1;
    for (int k = 0; k < 3 * HT; k++) begin
      if (hs_fall < 0 && !hs_a[k]) hs_fall = k;
      if (k > 0 && de_rise2 < 0 && de_a[k] && !de_a[k - 1]) de_rise2 = k;
    end
    if (hs_fall >= 0) begin
      while (hs_fall + hs_len < 3 * HT && !hs_a[hs_fall + hs_len]) hs_len++;
      for (int k = hs_fall + hs_len; k < 3 * HT; k++) begin
        if (!hs_a[k]) begin
          hs_fall2 = k;
          break;
        end
      end
    end
    n_checks++;
    if (de_run != HA) begin
      n_fail++;
      $display("FAIL %s de width: %0d strobes expected %0d", name, de_run, HA);
    end
    n_checks++;
    if (hs_fall != HA + HF) begin
      n_fail++;
      $display("FAIL %s hsync start: %0d strobes after de rise expected %0d", name, hs_fall, HA + HF);
    end
    n_checks++;
    if (hs_len != HS) begin
      n_fail++;
      $display("FAIL %s hsync width: %0d expected %0d", name, hs_len, HS);
    end
    n_checks++;
    if (de_rise2 != HT || hs_fall2 - hs_fall != HT) begin
      n_fail++;
      $display("FAIL %s line period: de %0d hsync %0d expected %0d", name, de_rise2, hs_fall2 - hs_fall, HT);
    end
    n_checks++;
    if (static_err != s0) begin
      n_fail++;
      $display("FAIL %s outputs moved between strobes %0d times, expected 0", name, static_err - s0);
    end
  endtask

  task automatic test_line_timing();
    bit found;
    wait_fs(found);
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL line timing: no frame_start within %0d strobes", FRAME + 4);
    end else begin
      measure_lines("line timing");
    end
  endtask

  task automatic test_frame_timing();
    bit found;
    int period, vs_fall, vs_len, f0;
    wait_fs(found);
    f0 = fs_long;
    period = -1; vs_fall = -1; vs_len = 0;
    if (found) begin
      for (int k = 1; k < FRAME + 4; k++) begin
        strobe();
        if (!o_vs) begin
          if (vs_fall < 0) vs_fall = k;
          vs_len++;
        end
        if (o_fs) begin
          period = k;
          break;
        end
      end
    end
    n_checks++;
    if (period != FRAME) begin
      n_fail++;
      $display("FAIL frame period: %0d strobes expected %0d", period, FRAME);
    end
    n_checks++;
    if (vs_fall != (VA + VF) * HT) begin
      n_fail++;
      $display("FAIL vsync start: %0d strobes after frame_start expected %0d", vs_fall, (VA + VF) * HT);
    end
    n_checks++;
    if (vs_len != VS * HT) begin
      n_fail++;
      $display("FAIL vsync width: %0d strobes expected %0d", vs_len, VS * HT);
    end
    n_checks++;
    if (fs_long != f0) begin
      n_fail++;
      $display("FAIL frame_start width: held %0d extra clks, expected 0", fs_long - f0);
    end
  endtask

  task automatic test_midframe_reset();
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < FRAME + 1; i++) begin
      strobe();
      if (px_x(j - 1) == 5 && px_y(j - 1) == 20) begin
        hit = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!hit) begin
      n_fail++;
      $display("FAIL midreset: line 20 not reached");
    end
    @(negedge clk);
    rst_n = 1'b0;
    pix_en = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if ({pixel, de, hsync, vsync, frame_start} !== 5'b00110 || text_addr !== '0) begin
      n_fail++;
      $display("FAIL midreset values: px/de/hs/vs/fs=%b addr=%0d, expected 00110 addr=0",
               {pixel, de, hsync, vsync, frame_start}, text_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    pix_en = 1'b0;
    j = 0;
    strobe();
    n_checks++;
    if (o_fs !== 1'b0 || o_de !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset strobe1: fs=%b de=%b expected 0 0", o_fs, o_de);
    end
    strobe();
    n_checks++;
    if (o_fs !== 1'b1 || o_de !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset strobe2: fs=%b de=%b expected 1 1", o_fs, o_de);
    end
    measure_lines("post-reset lines");
  endtask

  initial begin
    for (int a = 0; a < (1 << AW); a++) mem[a] = 7'h41;
    test_reset();
    test_scan("glyph 0x41", FRAME + HT, 1'b0, 1'b0);
    test_scan("random text", HT * 10, 1'b1, 1'b1);
    test_addressing();
    test_line_timing();
    test_frame_timing();
    test_midframe_reset();
    test_scan("after reset", HT * 4, 1'b1, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
